mux2_sync: RTL and testbench

- Parameterised 2:1 word multiplexer used as a generic datapath selector.
- Provides a combinational select path, `out`, and a registered copy, `out_q`, for timing-critical consumers.
- The registered stage has one clock, a synchronous active-high reset and a load enable.
- Sits between operand sources and downstream ALU/register-file inputs.

---
 rtl/mux2_sync.sv | 72 +++++++
 tb/tb_mux2_sync.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mux2_sync.sv
// Parameterised 2:1 word multiplexer with a combinational output and a registered, load-enabled copy.
// Optional macro MUX2_SYNC_SEL_COUNT_EN adds an 8-bit saturating counter of select changes (sel_changes).
module mux2_sync #(
  parameter int          WIDTH   = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sw,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             q_valid
`ifdef MUX2_SYNC_SEL_COUNT_EN
  ,
  output logic [7:0]       sel_changes
`endif
);

  // RST_VAL is zero-extended or truncated to the data width
  localparam logic [WIDTH-1:0] RST_VAL_W = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] sel_s;
  logic [WIDTH-1:0] out_q_r;
  logic             q_valid_r;

  // Combinational selection; an unknown sw propagates as X in simulation
  assign sel_s = sw ? b : a;
  assign out   = sel_s;

  // Registered copy of the selection; reset takes priority over the load enable
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q_r   <= RST_VAL_W;
      q_valid_r <= 1'b0;
    end else if (en) begin
      out_q_r   <= sel_s;
      q_valid_r <= 1'b1;
    end else begin
      out_q_r   <= out_q_r;
      q_valid_r <= q_valid_r;
    end
  end

  assign out_q   = out_q_r;
  assign q_valid = q_valid_r;

`ifdef MUX2_SYNC_SEL_COUNT_EN
  logic       sw_prev_r;
  logic [7:0] sel_cnt_r;

  // Count edges where sw differs from the previous edge, saturating at 255 and ignoring en
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_prev_r <= 1'b0;
      sel_cnt_r <= 8'd0;
    end else begin
      sw_prev_r <= sw;
      if ((sw != sw_prev_r) && (sel_cnt_r != 8'd255)) begin
        sel_cnt_r <= sel_cnt_r + 8'd1;
      end else begin
        sel_cnt_r <= sel_cnt_r;
      end
    end
  end

  assign sel_changes = sel_cnt_r;
`endif

endmodule

// File: tb/tb_mux2_sync.sv
// Self-checking bench for mux2_sync: directed scenarios followed by randomized traffic against a rule-level model.
module tb_mux2_sync;

  logic       clk = 1'b0;
  logic       reset, sw, en;
  logic [3:0] a, b;
  logic [3:0] out, out_q, out2, out_q2;
  logic       q_valid, q_valid2;
`ifdef MUX2_SYNC_SEL_COUNT_EN
  logic [7:0] sel_changes, sel_changes2;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [3:0] m_q, m_q2;
  logic       m_valid;
  int         m_cnt;
  logic       m_prev;

  mux2_sync dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .sw(sw), .en(en),
    .out(out), .out_q(out_q), .q_valid(q_valid)
`ifdef MUX2_SYNC_SEL_COUNT_EN
    , .sel_changes(sel_changes)
`endif
  );

  // Second instance checks a non-zero reset value that must be truncated (25 -> 4'h9)
  mux2_sync #(.WIDTH(4), .RST_VAL(25)) dut2 (
    .clk(clk), .reset(reset), .a(a), .b(b), .sw(sw), .en(en),
    .out(out2), .out_q(out_q2), .q_valid(q_valid2)
`ifdef MUX2_SYNC_SEL_COUNT_EN
    , .sel_changes(sel_changes2)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] pick(input logic [3:0] x, input logic [3:0] y, input logic s);
    logic [3:0] pair [2];
    pair[0] = x;
    pair[1] = y;
    return pair[s];
  endfunction

  // Advance one edge, apply the rules to the model, then compare registered outputs
  task automatic step();
    @(posedge clk);
    if (reset) begin
      m_q     = 4'd0;
      m_q2    = 4'd9;
      m_valid = 1'b0;
      m_cnt   = 0;
      m_prev  = 1'b0;
    end else begin
      if (en) begin
        m_q     = pick(a, b, sw);
        m_q2    = m_q;
        m_valid = 1'b1;
      end
      if (sw !== m_prev) m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
      m_prev = sw;
    end
    #1;
    check("out_q", {28'd0, out_q}, {28'd0, m_q});
    check("q_valid", {31'd0, q_valid}, {31'd0, m_valid});
    check("out_q_rst25", {28'd0, out_q2}, {28'd0, m_q2});
    check("q_valid_rst25", {31'd0, q_valid2}, {31'd0, m_valid});
`ifdef MUX2_SYNC_SEL_COUNT_EN
    check("sel_changes", {24'd0, sel_changes}, m_cnt);
    check("sel_changes2", {24'd0, sel_changes2}, m_cnt);
`endif
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; sw = 1'b0; a = 4'd0; b = 4'd0;
    m_q = 4'd0; m_q2 = 4'd9; m_valid = 1'b0; m_cnt = 0; m_prev = 1'b0;
    step();

    // Combinational path without any clock edge
    reset = 1'b0; sw = 1'b0; a = 4'b0011; b = 4'b1010;
    #1 check("comb_sel_a", {28'd0, out}, 32'h3);
    a = 4'b1100; b = 4'b0101;
    #1 check("comb_a_change", {28'd0, out}, 32'hC);
    sw = 1'b1;
    #1 check("comb_sel_b", {28'd0, out}, 32'h5);
    check("comb_inst2", {28'd0, out2}, 32'h5);

    // Registered load after a reset cycle
    reset = 1'b1;
    step();
    reset = 1'b0; en = 1'b1; sw = 1'b1; a = 4'b1100; b = 4'b0101;
    step();
    check("load_b", {28'd0, out_q}, 32'h5);

    // Hold with en low while inputs move
    en = 1'b0; sw = 1'b0; a = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_out_q", {28'd0, out_q}, 32'h5);
      check("hold_out", {28'd0, out}, 32'hF);
    end

    // Reset beats enable on the same edge, then loading resumes
    reset = 1'b1; en = 1'b1; sw = 1'b0; a = 4'b0011;
    step();
    check("rst_prio_q", {28'd0, out_q}, 32'h0);
    reset = 1'b0;
    step();
    check("resume_load", {28'd0, out_q}, 32'h3);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      a     = 4'($urandom);
      b     = 4'($urandom);
      sw    = 1'($urandom);
      en    = 1'($urandom);
      reset = ($urandom_range(0, 15) == 0);
      #1 check("rand_out", {28'd0, out}, {28'd0, pick(a, b, sw)});
      step();
    end

`ifdef MUX2_SYNC_SEL_COUNT_EN
    // Saturation of the select-change counter
    reset = 1'b1; en = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      sw = ~sw;
      step();
    end
    check("sel_sat", {24'd0, sel_changes}, 32'd255);
    reset = 1'b1;
    step();
    check("sel_clear", {24'd0, sel_changes}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
